// File: rtl/alu_arbiter.sv
// Shared ALU fronted by an N-way request arbiter with a one-deep result register.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module alu_arbiter #(
   parameter int DATA_SIZE = 32,
   parameter int FUNC_SIZE = 11,
   parameter int NUM_REQ   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   output logic [NUM_REQ-1:0]             o_req_ready,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_a,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_b,
   input  logic [NUM_REQ*FUNC_SIZE-1:0]   i_req_func,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [DATA_SIZE-1:0]           o_rsp_data,
   output logic [2:0]                     o_rsp_id,
   output logic                           o_rsp_err
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [FUNC_SIZE-1:0] FN_ADD = FUNC_SIZE'(1);
   localparam logic [FUNC_SIZE-1:0] FN_SUB = FUNC_SIZE'(2);
   localparam logic [FUNC_SIZE-1:0] FN_AND = FUNC_SIZE'(3);
   localparam logic [FUNC_SIZE-1:0] FN_OR  = FUNC_SIZE'(4);
   localparam logic [FUNC_SIZE-1:0] FN_XOR = FUNC_SIZE'(5);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_SIZE-1:0]   r_rsp_data;
   logic [2:0]             r_rsp_id;
   logic                   r_rsp_err;
   logic                   w_slot_free;
   logic                   w_win_any;
   logic [2:0]             w_win_idx;
   logic                   w_fire;
   logic [NUM_REQ-1:0]     w_grant;
   logic [DATA_SIZE-1:0]   w_a;
   logic [DATA_SIZE-1:0]   w_b;
   logic [FUNC_SIZE-1:0]   w_func;
   logic [DATA_SIZE-1:0]   w_res;
   logic                   w_err;

   assign w_slot_free = (r_state == IDLE) | i_rsp_ready;

`ifdef ALU_ARBITER_RR_EN
   logic [2:0] r_ptr;
   logic       w_hi_any;
   logic [2:0] w_hi_idx;

   // Round-robin: lowest valid index at or above the pointer, else wrap to lowest valid overall
   always_comb begin
      w_hi_any  = 1'b0;
      w_hi_idx  = 3'd0;
      w_win_any = 1'b0;
      w_win_idx = 3'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_valid[i]) begin
            w_win_any = 1'b1;
            w_win_idx = 3'(i);
            if (3'(i) >= r_ptr) begin
               w_hi_any = 1'b1;
               w_hi_idx = 3'(i);
            end else begin
               w_hi_any = w_hi_any;
            end
         end else begin
            w_win_any = w_win_any;
         end
      end
      if (w_hi_any) begin
         w_win_idx = w_hi_idx;
      end else begin
         w_win_idx = w_win_idx;
      end
   end

   // Pointer moves only when a request is actually consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 3'd0;
      end else if (w_fire) begin
         r_ptr <= (w_win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_win_idx + 3'd1;
      end
   end
`else
   // Fixed priority: the lowest valid index wins
   always_comb begin
      w_win_any = 1'b0;
      w_win_idx = 3'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_valid[i]) begin
            w_win_any = 1'b1;
            w_win_idx = 3'(i);
         end else begin
            w_win_any = w_win_any;
         end
      end
   end
`endif

   assign w_fire = w_win_any & w_slot_free & rst_n;

   // One-hot grant plus operand selection for the single shared ALU
   always_comb begin
      w_grant = '0;
      w_a     = '0;
      w_b     = '0;
      w_func  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_grant[i] = w_fire & (w_win_idx == 3'(i));
         if (w_win_idx == 3'(i)) begin
            w_a    = i_req_a[i*DATA_SIZE +: DATA_SIZE];
            w_b    = i_req_b[i*DATA_SIZE +: DATA_SIZE];
            w_func = i_req_func[i*FUNC_SIZE +: FUNC_SIZE];
         end else begin
            w_a = w_a;
         end
      end
   end

   assign o_req_ready = w_grant;

   // ALU datapath; unsupported codes yield zero and flag an error
   always_comb begin
      w_res = '0;
      w_err = 1'b0;
      case (w_func)
         FN_ADD:  w_res = w_a + w_b;
         FN_SUB:  w_res = w_a - w_b;
         FN_AND:  w_res = w_a & w_b;
         FN_OR:   w_res = w_a | w_b;
         FN_XOR:  w_res = w_a ^ w_b;
         default: begin
            w_res = '0;
            w_err = 1'b1;
         end
      endcase
   end

   // Next state: a transfer always fills the slot, a drain without refill empties it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_fire) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (w_fire) begin
               w_state_nxt = HOLD;
            end else if (i_rsp_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rsp_data <= '0;
         r_rsp_id   <= 3'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fire) begin
            r_rsp_data <= w_res;
            r_rsp_id   <= w_win_idx;
            r_rsp_err  <= w_err;
         end
      end
   end

   assign o_rsp_valid = (r_state == HOLD);
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_err   = r_rsp_err;

endmodule
